irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (1..8); unused source bits read 0.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on src inputs (0 or 2).
REQ-003 SHALL have port clk  input  1  CPU clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port addr  input  3  register select.
REQ-006 SHALL have port dbw  input  8  CPU write data.
REQ-007 SHALL have port we  input  1  write strobe, pre-qualified by the block's address decode.
REQ-008 SHALL have port dbr  output  8  read data, registered.
REQ-009 SHALL have port src  input  NUM_SRC  interrupt requests; bit 0 is highest priority.
REQ-010 SHALL have port irq  output  1  registered interrupt request to the CPU, active-high.

Function
REQ-011 Register map: 0 PEND (R, W1C); 1 MASK (R/W); 2 MODE (R/W, 1=edge, 0=level); 3 POL (R/W, 1=active-high/rising); 4 VEC (R: bit7=any active, bits2:0=index; W: acknowledge); 5 FORCE (W only, reads 0x00); 6 ACTIVE (R, PEND & MASK); 7 reserved (reads 0x00, writes ignored).
REQ-012 Each source SHALL be XOR-adjusted by POL after SYNC_STAGES flops, giving the adjusted level a[i].
REQ-013 Level mode: PEND[i] SHALL equal a[i] registered; W1C, FORCE and VEC ack SHALL have no effect on it.
REQ-014 Edge mode: PEND[i] SHALL set on the cycle a[i] goes 0->1 versus its previous sample, and stay set until cleared.
REQ-015 Edge-mode clear: writing PEND with bit i=1, or VEC with dbw[2:0]=i, SHALL clear PEND[i].
REQ-016 FORCE write with bit i=1 SHALL set PEND[i] when MODE[i]=1.
REQ-017 Set (edge or FORCE) and clear in the same cycle for one bit SHALL leave the bit set.
REQ-018 VEC read bits2:0 SHALL be the lowest index i with PEND[i]&MASK[i]; bit7=0 and bits2:0=0 if none; bits6:3 always 0.
REQ-019 irq SHALL be the registered OR of PEND & MASK, asserted one cycle after PEND updates.
REQ-020 With SYNC_STAGES=0, src rising edge sampled at edge k SHALL give PEND at k and irq at k+1; each sync stage SHALL add one cycle.
REQ-021 dbr SHALL present the register selected by addr sampled at edge k, valid after edge k, with contents as of edge k.
REQ-022 Writing POL or MODE SHALL take effect next cycle; a resulting 0->1 of a[i] in edge mode SHALL set PEND[i].
REQ-023 Switching MODE[i] edge->level SHALL make PEND[i] follow a[i] next cycle.
REQ-024 Reads SHALL have no side effects.

Reset
REQ-025 While rst=0: PEND=0, MASK=0x00, MODE=0x00, POL=0xFF, sync/previous-sample flops=0, irq=0, dbr=0x00.
REQ-026 Reset asserted mid-operation SHALL clear pending edges immediately and drop irq asynchronously.

Structure
REQ-027 Register offsets and VEC field positions SHALL live in shared package irq_ctrl_pkg.
REQ-028 Per-source logic (sync, polarity, edge detect, pending flop) SHALL be sub-module irq_src_cell, instantiated NUM_SRC times.

Verification
REQ-029 MASK=0x04, MODE=0x04, src[2] 0->1 -> PEND=0x04, irq=1 after 2+SYNC_STAGES cycles; VEC read=0x82.
REQ-030 src[5] and src[1] pending, MASK=0xFF -> VEC=0x81; write VEC=0x01 -> VEC=0x85; write PEND=0x20 -> irq=0 next cycle.
REQ-031 Level mode, POL[3]=0, src[3]=0 -> PEND[3]=1; W1C 0x08 ignored; src[3]=1 -> PEND[3]=0.
REQ-032 Edge on src[0] in the same cycle as PEND write 0x01 -> PEND[0] stays 1.
REQ-033 MODE=0x80, FORCE write 0x80 -> PEND=0x80, irq=0 until MASK=0x80, then irq=1 next cycle.
REQ-034 rst pulsed low with irq=1 -> irq=0 and all registers at reset values without a clock edge.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared definitions for the interrupt controller: register
//               offsets, VEC read-field positions, reset values and a
//               lowest-set-bit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    // Register offsets on the 3-bit addr bus
    localparam logic [2:0] c_ADDR_PEND   = 3'd0;  // R, W1C (edge-mode bits)
    localparam logic [2:0] c_ADDR_MASK   = 3'd1;  // R/W
    localparam logic [2:0] c_ADDR_MODE   = 3'd2;  // R/W, 1 = edge, 0 = level
    localparam logic [2:0] c_ADDR_POL    = 3'd3;  // R/W, 1 = active-high/rising
    localparam logic [2:0] c_ADDR_VEC    = 3'd4;  // R: vector, W: acknowledge
    localparam logic [2:0] c_ADDR_FORCE  = 3'd5;  // W only, reads zero
    localparam logic [2:0] c_ADDR_ACTIVE = 3'd6;  // R, PEND & MASK
    localparam logic [2:0] c_ADDR_RSVD   = 3'd7;  // reads zero, writes ignored

    // VEC read-data field layout
    localparam int c_VEC_ANY_BIT = 7;
    localparam int c_VEC_IDX_LSB = 0;
    localparam int c_VEC_IDX_W   = 3;

    // Register reset values
    localparam logic [7:0] c_RST_MASK = 8'h00;
    localparam logic [7:0] c_RST_MODE = 8'h00;
    localparam logic [7:0] c_RST_POL  = 8'hFF;

    // Index of the lowest set bit (bit 0 has highest priority); 0 when none.
    function automatic logic [c_VEC_IDX_W-1:0] lowest_set(input logic [7:0] v);
        lowest_set = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = c_VEC_IDX_W'(i);
            end
        end
    endfunction

    // Assemble the VEC read value from the masked pending vector.
    function automatic logic [7:0] vec_word(input logic [7:0] act);
        logic [7:0] w;
        w = 8'h00;
        if (|act) begin
            w[c_VEC_ANY_BIT] = 1'b1;
            w[c_VEC_IDX_LSB +: c_VEC_IDX_W] = lowest_set(act);
        end
        return w;
    endfunction

endpackage : irq_ctrl_pkg
`default_nettype wire

// File: rtl/irq_src_cell.sv
`default_nettype none
// ============================================================================
// Module      : irq_src_cell
// Description : One interrupt source: optional synchroniser, polarity
//               adjust, rising-edge detect and the pending flop.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-low reset
//               req       - raw interrupt request from outside
//               pol       - 1 = active-high/rising, 0 = active-low/falling
//               edge_mode - 1 = edge (latched), 0 = level (follows input)
//               set_force - software set, honoured in edge mode only
//               clr       - software clear (W1C or VEC acknowledge)
//               pend      - pending state
// Revision    : 1.0 - initial release
// ============================================================================
module irq_src_cell #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic pol,
    input  logic edge_mode,
    input  logic set_force,
    input  logic clr,
    output logic pend
);

    logic w_sync;
    logic w_adj;
    logic w_rise;
    logic r_prev;
    logic r_pend;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign w_sync = req;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= req;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= r_sync[s-1];
                    end
                end
            end
            assign w_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // pol=1 passes the input through, pol=0 inverts it
    assign w_adj  = w_sync ^ ~pol;
    assign w_rise = w_adj & ~r_prev;

    // The previous sample tracks in both modes so that a switch into edge
    // mode does not see a stale 0 and fire a spurious edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_prev <= w_adj;
            if (edge_mode) begin
                // a set in the same cycle as a clear wins
                r_pend <= w_rise | set_force | (r_pend & ~clr);
            end else begin
                r_pend <= w_adj;
            end
        end
    end

    assign pend = r_pend;

endmodule : irq_src_cell
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Small CPU-mapped interrupt controller with up to 8 sources,
//               per-source mask / mode / polarity, software force, W1C and
//               vector acknowledge, and a registered irq output.
// Ports       : clk  - CPU clock, rising edge
//               rst  - asynchronous active-low reset
//               addr - register select
//               dbw  - write data
//               we   - write strobe (already address-qualified)
//               dbr  - registered read data
//               src  - interrupt requests, bit 0 highest priority
//               irq  - registered interrupt request, active-high
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         addr,
    input  logic [7:0]         dbw,
    input  logic               we,
    output logic [7:0]         dbr,
    input  logic [NUM_SRC-1:0] src,
    output logic               irq
);

    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_mode;
    logic [NUM_SRC-1:0] r_pol;
    logic [NUM_SRC-1:0] w_pend;
    logic [NUM_SRC-1:0] w_set_force;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_active;
    logic [7:0]         r_dbr;
    logic               r_irq;
    logic [7:0]         w_rdata;
    logic               w_wr_pend;
    logic               w_wr_vec;
    logic               w_wr_force;

    assign w_wr_pend  = we && (addr == c_ADDR_PEND);
    assign w_wr_vec   = we && (addr == c_ADDR_VEC);
    assign w_wr_force = we && (addr == c_ADDR_FORCE);

    assign w_active = w_pend & r_mask;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            assign w_set_force[i] = w_wr_force & dbw[i];
            // W1C bit or a VEC acknowledge naming this index
            assign w_clr[i] = (w_wr_pend & dbw[i]) |
                              (w_wr_vec & (dbw[2:0] == 3'(i)));

            irq_src_cell #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_cell (
                .clk       (clk),
                .rst       (rst),
                .req       (src[i]),
                .pol       (r_pol[i]),
                .edge_mode (r_mode[i]),
                .set_force (w_set_force[i]),
                .clr       (w_clr[i]),
                .pend      (w_pend[i])
            );
        end
    endgenerate

    // Configuration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= c_RST_MASK[NUM_SRC-1:0];
            r_mode <= c_RST_MODE[NUM_SRC-1:0];
            r_pol  <= c_RST_POL[NUM_SRC-1:0];
        end else if (we) begin
            case (addr)
                c_ADDR_MASK: r_mask <= dbw[NUM_SRC-1:0];
                c_ADDR_MODE: r_mode <= dbw[NUM_SRC-1:0];
                c_ADDR_POL:  r_pol  <= dbw[NUM_SRC-1:0];
                default: ;
            endcase
        end
    end

    // Read mux; unused source bits read as zero
    always_comb begin
        w_rdata = 8'h00;
        case (addr)
            c_ADDR_PEND:   w_rdata = 8'(w_pend);
            c_ADDR_MASK:   w_rdata = 8'(r_mask);
            c_ADDR_MODE:   w_rdata = 8'(r_mode);
            c_ADDR_POL:    w_rdata = 8'(r_pol);
            c_ADDR_VEC:    w_rdata = vec_word(8'(w_active));
            c_ADDR_ACTIVE: w_rdata = 8'(w_active);
            default:       w_rdata = 8'h00;
        endcase
    end

    // Read data and irq are both registered from pre-edge state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dbr <= 8'h00;
            r_irq <= 1'b0;
        end else begin
            r_dbr <= w_rdata;
            r_irq <= |w_active;
        end
    end

    assign dbr = r_dbr;
    assign irq = r_irq;

endmodule : irq_ctrl
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Self-checking bench for irq_ctrl: directed scenarios followed
//               by random register traffic and source activity, compared
//               every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    localparam int NSRC = 8;
    localparam int SYNC = 2;

    logic       clk;
    logic       rst;
    logic [2:0] addr;
    logic [7:0] dbw;
    logic       we;
    logic [7:0] dbr;
    logic [7:0] src;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    logic [7:0] m_mask, m_mode, m_pol, m_pend, m_prev, m_dbr;
    logic       m_irq;
    logic [7:0] m_sync[$];

    irq_ctrl #(
        .NUM_SRC     (NSRC),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .dbw  (dbw),
        .we   (we),
        .dbr  (dbr),
        .src  (src),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mask = 8'h00;
        m_mode = 8'h00;
        m_pol  = 8'hFF;
        m_pend = 8'h00;
        m_prev = 8'h00;
        m_dbr  = 8'h00;
        m_irq  = 1'b0;
        m_sync = {};
        repeat (SYNC) m_sync.push_back(8'h00);
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] a);
        logic [7:0] act;
        act = m_pend & m_mask;
        case (a)
            3'd0: return m_pend;
            3'd1: return m_mask;
            3'd2: return m_mode;
            3'd3: return m_pol;
            3'd4: begin
                for (int i = 0; i < 8; i++) begin
                    if (act[i]) return 8'h80 | 8'(i);
                end
                return 8'h00;
            end
            3'd6: return act;
            default: return 8'h00;
        endcase
    endfunction

    // Apply the rules for one rising edge using the inputs present at it.
    task automatic model_edge();
        logic [7:0] seen, a, nxt;
        logic       set, clr;
        if (SYNC == 0) begin
            seen = src;
        end else begin
            seen = m_sync.pop_front();
            m_sync.push_back(src);
        end
        a     = seen ^ ~m_pol;
        m_dbr = model_read(addr);
        m_irq = |(m_pend & m_mask);
        for (int i = 0; i < 8; i++) begin
            if (m_mode[i]) begin
                set = (a[i] && !m_prev[i]) || (we && addr == 3'd5 && dbw[i]);
                clr = we && ((addr == 3'd0 && dbw[i]) ||
                             (addr == 3'd4 && int'(dbw[2:0]) == i));
                nxt[i] = set || (m_pend[i] && !clr);
            end else begin
                nxt[i] = a[i];
            end
        end
        m_pend = nxt;
        m_prev = a;
        if (we) begin
            if (addr == 3'd1) m_mask = dbw;
            if (addr == 3'd2) m_mode = dbw;
            if (addr == 3'd3) m_pol  = dbw;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("dbr", dbr, m_dbr);
        chk("irq", {7'd0, irq}, {7'd0, m_irq});
    endtask

    task automatic drive(input logic [2:0] a, input logic [7:0] d,
                         input logic w, input logic [7:0] s);
        addr = a;
        dbw  = d;
        we   = w;
        src  = s;
        cycle();
        we   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        drive(a, 8'h00, 1'b0, src);
        chk(tag, dbr, exp);
    endtask

    // Reset asserted part-way through a cycle; outputs must drop at once.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_irq", {7'd0, irq}, 8'h00);
        chk("rst_async_dbr", dbr, 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_irq", {7'd0, irq}, 8'h00);
        chk("rst_hold_dbr", dbr, 8'h00);
        rst = 1'b1;
    endtask

    initial begin
        rst  = 1'b0;
        addr = 3'd0;
        dbw  = 8'h00;
        we   = 1'b0;
        src  = 8'h00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_dbr", dbr, 8'h00);
        chk("reset_irq", {7'd0, irq}, 8'h00);
        rst = 1'b1;

        rd(3'd1, 8'h00, "reset_mask");
        rd(3'd2, 8'h00, "reset_mode");
        rd(3'd3, 8'hFF, "reset_pol");
        rd(3'd0, 8'h00, "reset_pend");

        // single edge source, priority vector
        drive(3'd1, 8'h04, 1'b1, 8'h00);
        drive(3'd2, 8'h04, 1'b1, 8'h00);
        drive(3'd0, 8'h00, 1'b0, 8'h04);
        repeat (4) drive(3'd0, 8'h00, 1'b0, 8'h04);
        chk("edge_irq", {7'd0, irq}, 8'h01);
        rd(3'd0, 8'h04, "edge_pend");
        rd(3'd4, 8'h82, "edge_vec");

        // two sources, acknowledge via VEC, clear via W1C
        do_reset();
        drive(3'd2, 8'h22, 1'b1, 8'h00);
        drive(3'd1, 8'hFF, 1'b1, 8'h00);
        repeat (4) drive(3'd0, 8'h00, 1'b0, 8'h22);
        rd(3'd4, 8'h81, "vec_two");
        rd(3'd6, 8'h22, "active_two");
        drive(3'd7, 8'hAA, 1'b1, src);
        rd(3'd7, 8'h00, "reserved_rd");
        rd(3'd5, 8'h00, "force_rd");
        drive(3'd4, 8'h01, 1'b1, src);
        rd(3'd4, 8'h85, "vec_after_ack");
        drive(3'd0, 8'h20, 1'b1, src);
        drive(3'd0, 8'h00, 1'b0, src);
        chk("irq_after_w1c", {7'd0, irq}, 8'h00);

        // level mode with inverted polarity
        do_reset();
        drive(3'd3, 8'hF7, 1'b1, 8'h00);
        repeat (2) drive(3'd0, 8'h00, 1'b0, 8'h00);
        rd(3'd0, 8'h08, "level_low_pend");
        drive(3'd0, 8'h08, 1'b1, 8'h00);
        rd(3'd0, 8'h08, "level_w1c_ignored");
        repeat (4) drive(3'd0, 8'h00, 1'b0, 8'h08);
        rd(3'd0, 8'h00, "level_high_pend");

        // edge set and W1C clear in the same cycle
        do_reset();
        drive(3'd2, 8'h01, 1'b1, 8'h00);
        drive(3'd0, 8'h00, 1'b0, 8'h01);
        drive(3'd0, 8'h00, 1'b0, 8'h01);
        drive(3'd0, 8'h01, 1'b1, 8'h01);
        rd(3'd0, 8'h01, "set_beats_clear");
        drive(3'd0, 8'h01, 1'b1, 8'h01);
        rd(3'd0, 8'h00, "w1c_clears");

        // force, masked irq, then async reset with irq high
        do_reset();
        drive(3'd2, 8'h80, 1'b1, 8'h00);
        drive(3'd5, 8'h80, 1'b1, 8'h00);
        rd(3'd0, 8'h80, "force_pend");
        chk("force_masked_irq", {7'd0, irq}, 8'h00);
        drive(3'd1, 8'h80, 1'b1, 8'h00);
        chk("mask_write_irq_lag", {7'd0, irq}, 8'h00);
        drive(3'd0, 8'h00, 1'b0, 8'h00);
        chk("mask_irq_on", {7'd0, irq}, 8'h01);
        rd(3'd3, 8'hFF, "pol_before_rst");
        do_reset();
        rd(3'd0, 8'h00, "post_rst_pend");
        rd(3'd1, 8'h00, "post_rst_mask");
        rd(3'd2, 8'h00, "post_rst_mode");
        rd(3'd3, 8'hFF, "post_rst_pol");

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] s;
            s = src;
            if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
            drive(3'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom_range(0, 2) == 0), s);
            if (n == 700) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_irq_ctrl
`default_nettype wire
